// File: rtl/mips_pkg.sv
// Shared fetch-path types: instruction/pc widths, the nop encoding and the queue storage word.
package mips_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_ptr.sv
// Modulo-DEPTH queue pointer; clr wins over inc, natural wrap on a power-of-two depth.
// Latency: new value visible the cycle after the edge. No backpressure of its own.
// Backpressure: none; callers only pulse inc on an accepted transfer.
module fetch_queue_ptr
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] ptr
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode prefetch FIFO with synchronous flush; FETCH_QUEUE_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle push-to-head (0 cycles through the bypass when enabled).
// Backpressure: in_ready drops only when full, independent of out_ready.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INST_W = mips_pkg::INST_W,
  parameter int PC_W   = mips_pkg::PC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_d;
  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];
  fq_entry_t     head;
  fq_entry_t     wr_entry;
  logic          full_c, empty_c;
  logic          push, pop, bypass;

  assign full_c   = (count_q == CW'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign in_ready = ~full_c & ~rst;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty_c & in_valid & in_ready & out_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is handed straight to decode, so it is never written.
  assign push = in_valid & in_ready & ~flush & ~bypass;
  assign pop  = ~empty_c & out_ready & ~flush;

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .clr (flush),
    .ptr (wr_ptr)
  );

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .clr (flush),
    .ptr (rd_ptr)
  );

  always_comb begin
    wr_entry.pc   = in_pc;
    wr_entry.inst = in_inst;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = wr_entry;
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = mem_q[rd_ptr];

  always_comb begin
    out_valid = ~empty_c | bypass;
    out_inst  = NOP_INST;
    out_pc    = '0;
    if (bypass) begin
      out_inst = in_inst;
      out_pc   = in_pc;
    end else if (!empty_c) begin
      out_inst = head.inst;
      out_pc   = head.pc;
    end
  end

  assign count = count_q;
  assign full  = full_c;
  assign empty = empty_c;

  a_no_push_full:  assert property (@(posedge clk) disable iff (rst) !(push && full_c));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(pop && empty_c));
  a_valid_holds:   assert property (@(posedge clk) disable iff (rst)
                     (in_valid && !in_ready && !flush) |=> (in_valid || flush));
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, out_valid, full, empty;
  logic [31:0] out_inst, out_pc;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after a falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
  endtask

  task automatic chk_state(input string tag, input int ecount, input logic eov,
                           input logic [31:0] epc, input logic [31:0] einst, input logic eir);
    chk({tag, ".count"},     64'(count),     64'(ecount));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(eov));
    chk({tag, ".out_pc"},    64'(out_pc),    64'(epc));
    chk({tag, ".out_inst"},  64'(out_inst),  64'(einst));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(eir));
    chk({tag, ".full"},      64'(full),      64'(ecount == DEPTH));
    chk({tag, ".empty"},     64'(empty),     64'(ecount == 0));
  endtask

  typedef struct {
    logic        r, f, iv;
    logic [31:0] pc, inst;
    logic        ordy;
    int          ecount;
    logic        eov;
    logic [31:0] epc, einst;
    logic        eir;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] pc, logic [31:0] inst,
                              logic ordy, int ecount, logic eov, logic [31:0] epc,
                              logic [31:0] einst, logic eir);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
    v.ecount = ecount; v.eov = eov; v.epc = epc; v.einst = einst; v.eir = eir;
    return v;
  endfunction

  // Reference model: the queue contents as a list of {pc, inst}.
  logic [63:0] mq[$];

  task automatic model_cycle(input string tag, output bit done);
    bit          byp;
    bit          acc;
    int          n;
    logic [31:0] epc, einst;
    n = mq.size();
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (n == 0) && in_valid && out_ready && !flush && !rst;
`else
    byp = 1'b0;
`endif
    epc = 32'h0; einst = 32'h0;
    if (byp) begin
      epc = in_pc; einst = in_inst;
    end else if (n > 0) begin
      epc = mq[0][63:32]; einst = mq[0][31:0];
    end
    chk_state(tag, n, (n > 0) || byp, epc, einst, (n < DEPTH) && !rst);
    acc = 1'b0;
    if (rst || flush) begin
      mq.delete();
    end else if (!byp) begin
      acc = in_valid && (n < DEPTH);
      if (out_ready && n > 0) void'(mq.pop_front());
      if (acc) mq.push_back({in_pc, in_inst});
    end
    done = acc || byp;
  endtask

  initial begin
    bit          done;
    logic        cur_v;
    logic [31:0] cur_pc, cur_inst, next_pc;
    logic        r, f, ordy;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 32'h99, 32'h99, 1);
    chk("reset.in_ready", 64'(in_ready), 64'd0);

    vt.push_back(mk(0,0,1, 0, 32'h00210820, 0,  0,0, 0, 0, 1));
    vt.push_back(mk(0,0,1, 4, 32'h8c010000, 0,  1,1, 0, 32'h00210820, 1));
    vt.push_back(mk(0,0,1, 8, 32'hac010000, 0,  2,1, 0, 32'h00210820, 1));
    vt.push_back(mk(0,0,1,12, 32'h20010001, 0,  3,1, 0, 32'h00210820, 1));
    vt.push_back(mk(0,0,0, 0, 0,            0,  4,1, 0, 32'h00210820, 0));
    vt.push_back(mk(0,0,0, 0, 0,            1,  4,1, 0, 32'h00210820, 0));
    vt.push_back(mk(0,0,0, 0, 0,            1,  3,1, 4, 32'h8c010000, 1));
    vt.push_back(mk(0,0,0, 0, 0,            1,  2,1, 8, 32'hac010000, 1));
    vt.push_back(mk(0,0,0, 0, 0,            1,  1,1,12, 32'h20010001, 1));
    vt.push_back(mk(0,0,0, 0, 0,            1,  0,0, 0, 0, 1));
    vt.push_back(mk(0,0,1,16, 32'h0000a001, 0,  0,0, 0, 0, 1));
    vt.push_back(mk(0,0,1,20, 32'h0000b002, 0,  1,1,16, 32'h0000a001, 1));
    vt.push_back(mk(0,0,1,24, 32'h0000c003, 0,  2,1,16, 32'h0000a001, 1));
    vt.push_back(mk(0,1,1,28, 32'h0000d004, 0,  3,1,16, 32'h0000a001, 1));
    vt.push_back(mk(0,0,1,44, 32'h0000e005, 0,  0,0, 0, 0, 1));
    vt.push_back(mk(0,0,0, 0, 0,            0,  1,1,44, 32'h0000e005, 1));
    vt.push_back(mk(0,0,0, 0, 0,            1,  1,1,44, 32'h0000e005, 1));
    vt.push_back(mk(0,0,0, 0, 0,            0,  0,0, 0, 0, 1));
`ifdef FETCH_QUEUE_BYPASS_EN
    vt.push_back(mk(0,0,1,32, 32'h20020020, 1,  0,1,32, 32'h20020020, 1));
    vt.push_back(mk(0,0,0, 0, 0,            0,  0,0, 0, 0, 1));
    vt.push_back(mk(0,0,0, 0, 0,            1,  0,0, 0, 0, 1));
`else
    vt.push_back(mk(0,0,1,32, 32'h20020020, 1,  0,0, 0, 0, 1));
    vt.push_back(mk(0,0,0, 0, 0,            0,  1,1,32, 32'h20020020, 1));
    vt.push_back(mk(0,0,0, 0, 0,            1,  1,1,32, 32'h20020020, 1));
`endif
    vt.push_back(mk(0,0,0, 0, 0,            0,  0,0, 0, 0, 1));

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].f, vt[i].iv, vt[i].pc, vt[i].inst, vt[i].ordy);
      chk_state($sformatf("vec%0d", i), vt[i].ecount, vt[i].eov, vt[i].epc, vt[i].einst, vt[i].eir);
    end

    // Steady push+pop at count 2: pointers wrap twice, head pc advances by 4 every cycle.
    drive(0, 0, 1, 100, 32'h100, 0);
    drive(0, 0, 1, 104, 32'h104, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 32'(108 + 4 * i), 32'(32'h108 + i), 1);
      chk($sformatf("stream%0d.count", i), 64'(count), 64'd2);
      chk($sformatf("stream%0d.pc", i), 64'(out_pc), 64'(100 + 4 * i));
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("stream.tail0", 64'(out_pc), 64'd140);
    drive(0, 0, 0, 0, 0, 1);
    chk("stream.tail1", 64'(out_pc), 64'd144);

    // Full stall: held entry is rejected during the pop cycle and taken next cycle.
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'(200 + 4 * i), 32'(i), 0);
    drive(0, 0, 1, 216, 32'h216, 1);
    chk("stall.in_ready", 64'(in_ready), 64'd0);
    chk("stall.count", 64'(count), 64'd4);
    drive(0, 0, 1, 216, 32'h216, 0);
    chk("stall.count_after", 64'(count), 64'd3);
    chk("stall.in_ready_after", 64'(in_ready), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    chk("stall.refill", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk($sformatf("stall.drain%0d", i), 64'(out_pc), 64'(204 + 4 * i));
    end

    // Randomised traffic against the queue model, with flushes and mid-run resets.
    mq.delete();
    drive(1, 0, 0, 0, 0, 0);
    model_cycle("rnd_rst", done);
    cur_v = 1'b0; cur_pc = '0; cur_inst = '0; next_pc = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      r    = ($urandom % 60) == 0;
      f    = ($urandom % 14) == 0;
      ordy = ($urandom % 3) != 0;
      if (!cur_v && ($urandom % 4) != 0) begin
        cur_v = 1'b1; cur_pc = next_pc; cur_inst = $urandom; next_pc = next_pc + 4;
      end
      drive(r, f, cur_v, cur_pc, cur_inst, ordy);
      model_cycle($sformatf("rnd%0d", c), done);
      if (done || f || r) cur_v = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
